gbf_out_writer: RTL and testbench

GBF_OUT_WRITER -- requirements
Module: gbf_out_writer

---
 rtl/gbf_out_writer_pkg.sv | 14 +
 rtl/gbf_out_writer_if.sv | 32 +++
 rtl/gbf_out_writer_rr_arbiter.sv | 48 ++++
 rtl/gbf_out_writer.sv | 133 +++++++++++++
 tb/tb_gbf_out_writer.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/gbf_out_writer_pkg.sv
// Shared types and constants for the global-buffer output writer.
package gbf_out_writer_pkg;

    // Width of each packed per-PE row/column index field.
    localparam int IDX_W = 8;

    // Collection pass state machine.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/gbf_out_writer_if.sv
// PE write-request bus and output-buffer write port of the output writer.
// The PE side drives requests through the master modport; the writer owns the
// grants and the buffer write port through the slave modport.
interface gbf_out_writer_if #(
    parameter int WIDTH      = 32,
    parameter int NUM_REQ    = 4,
    parameter int HEIGHT_OUT = 32
) ();
    import gbf_out_writer_pkg::*;

    localparam int AW = $clog2(HEIGHT_OUT);

    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*IDX_W-1:0] i_idx;
    logic [NUM_REQ*IDX_W-1:0] j_idx;
    logic [NUM_REQ*WIDTH-1:0] data_in;
    logic [NUM_REQ-1:0]       grant;
    logic                     we;
    logic [AW-1:0]            addr;
    logic [WIDTH-1:0]         wdata;

    modport master (
        output req, i_idx, j_idx, data_in,
        input  grant, we, addr, wdata
    );

    modport slave (
        input  req, i_idx, j_idx, data_in,
        output grant, we, addr, wdata
    );

endinterface

// File: rtl/gbf_out_writer_rr_arbiter.sv
// Round-robin arbiter: priority starts at the requester just after the last
// winner, and the pointer only moves when a grant is actually issued.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N-1:0]                    req,
    input  logic                            enable,
    output logic [N-1:0]                    grant,
    output logic [(N > 1 ? $clog2(N) : 1)-1:0] idx
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic          found;

    // Scan requesters starting at the pointer and pick the first one asserted.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        ptr_d = ptr_q;
        if (enable) begin
            for (int k = 0; k < N; k++) begin
                if (!found && req[(int'(ptr_q) + k) % N]) begin
                    found = 1'b1;
                    grant[(int'(ptr_q) + k) % N] = 1'b1;
                    idx = IW'((int'(ptr_q) + k) % N);
                end
            end
        end
        if (found) begin
            ptr_d = (idx == IW'(N - 1)) ? '0 : idx + IW'(1);
        end
    end

    // Priority pointer register, back to requester 0 on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/gbf_out_writer.sv
// Collects PE result words into the output buffer at address i*COL2+j.
// One grant per cycle, registered one cycle after the winner is sampled; the
// pass finishes once ROW1*COL2 valid writes have been issued.
module gbf_out_writer
    import gbf_out_writer_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int NUM_REQ    = 4,
    parameter int ROW1       = 2,
    parameter int COL2       = 5,
    parameter int HEIGHT_OUT = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    gbf_out_writer_if.slave   bus,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int AW    = $clog2(HEIGHT_OUT);
    localparam int IW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TOTAL = ROW1 * COL2;
    localparam int CNT_W = $clog2(TOTAL + 1);
    localparam int PW    = AW + IDX_W;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               err_q, err_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               we_q, we_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [WIDTH-1:0]   wdata_q, wdata_d;

    logic               arb_en;
    logic [NUM_REQ-1:0] arb_req;
    logic [NUM_REQ-1:0] arb_grant;
    logic [IW-1:0]      arb_idx;
    logic [IDX_W-1:0]   win_i;
    logic [IDX_W-1:0]   win_j;
    logic [WIDTH-1:0]   win_data;
    logic [AW-1:0]      win_addr;
    logic               win_in_range;

    // A requester whose grant is currently visible sits out this arbitration.
    assign arb_req = bus.req & ~grant_q;
    assign arb_en  = (state_q == ST_RUN);

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (arb_req),
        .enable (arb_en),
        .grant  (arb_grant),
        .idx    (arb_idx)
    );

    // Pull the winner's fields off the packed buses and form its buffer address.
    always_comb begin
        win_i        = bus.i_idx[arb_idx*IDX_W +: IDX_W];
        win_j        = bus.j_idx[arb_idx*IDX_W +: IDX_W];
        win_data     = bus.data_in[arb_idx*WIDTH +: WIDTH];
        win_addr     = AW'(PW'(win_i) * PW'(COL2) + PW'(win_j));
        win_in_range = (win_i < IDX_W'(ROW1)) && (win_j < IDX_W'(COL2));
    end

    // Next-state, write-count and registered write-port values.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        err_d   = err_q;
        grant_d = '0;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                    count_d = '0;
                    err_d   = 1'b0;
                end
            end
            ST_RUN: begin
                if (|arb_grant) begin
                    grant_d = arb_grant;
                    addr_d  = win_addr;
                    wdata_d = win_data;
                    if (win_in_range) begin
                        we_d    = 1'b1;
                        count_d = count_q + CNT_W'(1);
                        if (count_q + CNT_W'(1) == CNT_W'(TOTAL)) begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and write-port registers; reset drops any write in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            err_q   <= 1'b0;
            grant_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            err_q   <= err_d;
            grant_q <= grant_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus.grant = grant_q;
    assign bus.we    = we_q;
    assign bus.addr  = addr_q;
    assign bus.wdata = wdata_q;
    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign err       = err_q;

endmodule

// File: tb/tb_gbf_out_writer.sv
// Directed bench for gbf_out_writer with default parameters (2x5 result, 4 PEs).
module tb_gbf_out_writer;

    logic clk;
    logic rst;
    logic start;
    logic busy;
    logic done;
    logic err;

    int tests;
    int failures;

    gbf_out_writer_if #(.WIDTH(32), .NUM_REQ(4), .HEIGHT_OUT(32)) bus ();

    gbf_out_writer #(
        .WIDTH(32), .NUM_REQ(4), .ROW1(2), .COL2(5), .HEIGHT_OUT(32)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bus   (bus),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drive control inputs, then advance to 1 ns past the next rising edge.
    task automatic applyStimulus(input logic rst_v, input logic start_v,
                                 input logic [3:0] req_v);
        rst     = rst_v;
        start   = start_v;
        bus.req = req_v;
        @(posedge clk);
        #1;
    endtask

    task automatic setPe(input int p, input logic [7:0] i, input logic [7:0] j,
                         input logic [31:0] d);
        bus.i_idx[p*8 +: 8]     = i;
        bus.j_idx[p*8 +: 8]     = j;
        bus.data_in[p*32 +: 32] = d;
    endtask

    initial begin
        int exp_idx [5];
        tests       = 0;
        failures    = 0;
        rst         = 1'b1;
        start       = 1'b0;
        bus.req     = '0;
        bus.i_idx   = '0;
        bus.j_idx   = '0;
        bus.data_in = '0;

        // Reset state
        applyStimulus(1'b1, 1'b0, 4'b0000);
        applyStimulus(1'b1, 1'b0, 4'b0000);
        checkOutput("rst_grant", bus.grant, 0);
        checkOutput("rst_we",    bus.we,    0);
        checkOutput("rst_addr",  bus.addr,  0);
        checkOutput("rst_wdata", bus.wdata, 0);
        checkOutput("rst_busy",  busy,      0);
        checkOutput("rst_done",  done,      0);
        checkOutput("rst_err",   err,       0);

        // Requests before start are ignored in IDLE
        setPe(0, 8'd0, 8'd0, 32'h1000_0000);
        applyStimulus(1'b0, 1'b0, 4'b0001);
        checkOutput("idle_grant", bus.grant, 0);

        // Round-robin fairness: all four PEs hold req
        applyStimulus(1'b0, 1'b1, 4'b0000);
        checkOutput("start_busy", busy, 1);
        setPe(1, 8'd0, 8'd1, 32'h1000_0001);
        setPe(2, 8'd0, 8'd2, 32'h1000_0002);
        setPe(3, 8'd0, 8'd3, 32'h1000_0003);
        exp_idx = '{0, 1, 2, 3, 0};
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 1'b0, 4'b1111);
            checkOutput($sformatf("rr_grant%0d", k), bus.grant, 64'd1 << exp_idx[k]);
            checkOutput($sformatf("rr_we%0d", k), bus.we, 1);
            checkOutput($sformatf("rr_addr%0d", k), bus.addr, exp_idx[k]);
            checkOutput($sformatf("rr_wdata%0d", k), bus.wdata, 32'h1000_0000 + exp_idx[k]);
        end
        applyStimulus(1'b0, 1'b0, 4'b0000);
        checkOutput("rr_idle_grant", bus.grant, 0);
        checkOutput("rr_idle_we",    bus.we,    0);

        // Single write from PE1 at (1,3)
        setPe(1, 8'd1, 8'd3, 32'hDEAD_BEEF);
        applyStimulus(1'b0, 1'b0, 4'b0010);
        checkOutput("single_grant", bus.grant, 4'b0010);
        checkOutput("single_we",    bus.we,    1);
        checkOutput("single_addr",  bus.addr,  8);
        checkOutput("single_wdata", bus.wdata, 32'hDEAD_BEEF);
        applyStimulus(1'b0, 1'b0, 4'b0000);
        checkOutput("single_after_we", bus.we, 0);

        // Out-of-range row: grant without write, sticky err
        setPe(0, 8'd2, 8'd0, 32'hBAD0_0000);
        applyStimulus(1'b0, 1'b0, 4'b0001);
        checkOutput("oor_i_grant", bus.grant, 4'b0001);
        checkOutput("oor_i_we",    bus.we,    0);
        checkOutput("oor_i_err",   err,       1);
        applyStimulus(1'b0, 1'b0, 4'b0000);
        checkOutput("oor_err_sticky", err, 1);

        // Out-of-range column j == COL2
        setPe(2, 8'd0, 8'd5, 32'hBAD0_0002);
        applyStimulus(1'b0, 1'b0, 4'b0100);
        checkOutput("oor_j_grant", bus.grant, 4'b0100);
        checkOutput("oor_j_we",    bus.we,    0);

        // start in RUN is ignored: err stays set
        applyStimulus(1'b0, 1'b1, 4'b0000);
        checkOutput("run_start_err",  err,  1);
        checkOutput("run_start_busy", busy, 1);

        // Three more valid writes from PE3 (count 7..9), not yet done
        for (int k = 0; k < 3; k++) begin
            setPe(3, 8'd1, 8'(k), 32'h3000_0000 + k);
            applyStimulus(1'b0, 1'b0, 4'b1000);
            checkOutput($sformatf("fill_grant%0d", k), bus.grant, 4'b1000);
            checkOutput($sformatf("fill_addr%0d", k), bus.addr, 5 + k);
            applyStimulus(1'b0, 1'b0, 4'b0000);
            checkOutput($sformatf("fill_done%0d", k), done, 0);
        end

        // Tenth valid write: PE2 wins over PE3, PE3 left pending
        setPe(2, 8'd1, 8'd4, 32'h2000_0004);
        setPe(3, 8'd0, 8'd4, 32'h3000_0004);
        applyStimulus(1'b0, 1'b0, 4'b1100);
        checkOutput("last_grant", bus.grant, 4'b0100);
        checkOutput("last_we",    bus.we,    1);
        checkOutput("last_addr",  bus.addr,  9);
        checkOutput("last_done",  done,      1);
        checkOutput("last_busy",  busy,      0);
        applyStimulus(1'b0, 1'b0, 4'b1100);
        checkOutput("done_grant", bus.grant, 0);
        checkOutput("done_we",    bus.we,    0);
        checkOutput("done_err",   err,       1);

        // start from DONE clears err and re-enters RUN
        applyStimulus(1'b0, 1'b1, 4'b0000);
        checkOutput("restart_busy", busy, 1);
        checkOutput("restart_done", done, 0);
        checkOutput("restart_err",  err,  0);

        // Reset in the cycle a winner is sampled
        setPe(1, 8'd0, 8'd4, 32'h1111_1111);
        applyStimulus(1'b1, 1'b0, 4'b0010);
        checkOutput("rstmid_grant", bus.grant, 0);
        checkOutput("rstmid_we",    bus.we,    0);
        checkOutput("rstmid_busy",  busy,      0);
        applyStimulus(1'b0, 1'b0, 4'b0000);
        checkOutput("rstmid_idle_we", bus.we, 0);
        applyStimulus(1'b0, 1'b1, 4'b0000);
        setPe(0, 8'd0, 8'd0, 32'h1000_0000);
        setPe(2, 8'd0, 8'd2, 32'h1000_0002);
        setPe(3, 8'd0, 8'd3, 32'h1000_0003);
        applyStimulus(1'b0, 1'b0, 4'b1111);
        checkOutput("rstmid_resume_grant", bus.grant, 4'b0001);
        applyStimulus(1'b0, 1'b0, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
